// File: rtl/sweep_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sweep_pkg
//  Purpose  : Shared encodings for the truth-table sweeper: expected-function
//             mode codes and the sweep controller state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package sweep_pkg;

    // Expected reduction function applied to the stimulus vector
    localparam logic [1:0] MODE_AND  = 2'd0;
    localparam logic [1:0] MODE_OR   = 2'd1;
    localparam logic [1:0] MODE_XOR  = 2'd2;
    localparam logic [1:0] MODE_NAND = 2'd3;

    // Sweep controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sweep_ref_model.sv
`default_nettype none
// ============================================================================
//  Module   : sweep_ref_model
//  Purpose  : Combinational golden model. Produces the expected single-bit
//             response of a reduction gate (AND/OR/XOR/NAND) for a vector.
//  Revision : 1.0  initial release
// ============================================================================
module sweep_ref_model
    import sweep_pkg::*;
#(
    parameter int N_IN = 3
) (
    input  logic [N_IN-1:0] vec_i,
    input  logic [1:0]      mode_i,
    output logic            exp_o
);

    // Select the reduction matching the latched mode
    always_comb begin
        exp_o = 1'b0;
        case (mode_i)
            MODE_AND:  exp_o = &vec_i;
            MODE_OR:   exp_o = |vec_i;
            MODE_XOR:  exp_o = ^vec_i;
            MODE_NAND: exp_o = ~&vec_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ============================================================================
//  Module   : truth_table_sweeper
//  Purpose  : Exhaustive stimulus-and-check engine. Walks all 2^N_IN input
//             vectors, holds each for DWELL cycles, samples the DUT on the
//             last cycle and compares against the selected reduction.
//  Options  : SWEEP_FIRST_ERR_EN - build the first-mismatch capture register;
//             when undefined first_err_vec is tied to zero.
//  Revision : 1.0  initial release
// ============================================================================
module truth_table_sweeper
    import sweep_pkg::*;
#(
    parameter int N_IN  = 3,
    parameter int DWELL = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      mode,
    input  logic            dut_out,
    output logic [N_IN-1:0] vec_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt,
    output logic [N_IN-1:0] first_err_vec
);

    // A one-cycle dwell still needs a legal one-bit counter
    localparam int              CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [N_IN-1:0]  VEC_LAST = '1;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   vec_q,   vec_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [1:0]        mode_q,  mode_d;
    logic [N_IN:0]     err_q,   err_d;
    logic              pass_q,  pass_d;

    logic              w_expected;
    logic              w_accept;
    logic              w_sample;
    logic              w_mismatch;

    sweep_ref_model #(
        .N_IN   (N_IN)
    ) u_ref (
        .vec_i  (vec_q),
        .mode_i (mode_q),
        .exp_o  (w_expected)
    );

    assign w_accept   = (state_q == ST_IDLE) && start;
    assign w_sample   = (state_q == ST_RUN) && (cnt_q == CNT_LAST);
    assign w_mismatch = w_sample && (dut_out != w_expected);

    // Next-state logic: start acceptance, dwell stepping, scoring and finish
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        err_d   = err_q;
        pass_d  = pass_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    mode_d  = mode;
                    err_d   = '0;
                    pass_d  = 1'b0;
                    cnt_d   = '0;
                    vec_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (w_sample) begin
                    if (w_mismatch) begin
                        err_d = err_q + 1'b1;
                    end
                    if (vec_q == VEC_LAST) begin
                        // Final sample's contribution is already in err_d
                        state_d = ST_DONE;
                        pass_d  = (err_d == '0);
                    end else begin
                        vec_d = vec_q + 1'b1;
                        cnt_d = '0;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= MODE_AND;
            err_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
        end
    end

    assign busy    = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);
    assign vec_out = busy ? vec_q : '0;
    assign pass    = pass_q;
    assign err_cnt = err_q;

`ifdef SWEEP_FIRST_ERR_EN
    logic [N_IN-1:0] first_vec_q;
    logic            first_seen_q;

    // Capture the vector of the first mismatch; cleared by each accepted start
    always_ff @(posedge clk) begin
        if (reset) begin
            first_vec_q  <= '0;
            first_seen_q <= 1'b0;
        end else if (w_accept) begin
            first_vec_q  <= '0;
            first_seen_q <= 1'b0;
        end else if (w_mismatch && !first_seen_q) begin
            first_vec_q  <= vec_q;
            first_seen_q <= 1'b1;
        end
    end

    assign first_err_vec = first_vec_q;
`else
    assign first_err_vec = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
`default_nettype none
// ============================================================================
//  Module   : tb_truth_table_sweeper
//  Purpose  : Scoreboard bench for truth_table_sweeper. Instance A uses
//             N_IN=3/DWELL=4, instance B uses N_IN=4/DWELL=1. Expected sweep
//             results are queued at start; monitors pop them on done.
//  Revision : 1.0  initial release
// ============================================================================
module tb_truth_table_sweeper;
    import sweep_pkg::*;

`ifdef SWEEP_FIRST_ERR_EN
    localparam bit FE_ON = 1'b1;
`else
    localparam bit FE_ON = 1'b0;
`endif

    typedef struct {
        int err;
        int pass;
        int first;
        int busy;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a, start_b;
    logic [1:0] mode_a,  mode_b;
    logic [1:0] kind_a;
    logic       dut_a,   dut_b;

    logic [2:0] vec_a;
    logic       busy_a, done_a, pass_a;
    logic [3:0] err_a;
    logic [2:0] first_a;

    logic [3:0] vec_b;
    logic       busy_b, done_b, pass_b;
    logic [4:0] err_b;
    logic [3:0] first_b;

    int   checks = 0;
    int   errors = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;
    int   run_a = 0;
    int   run_b = 0;

    always #5 clk = ~clk;

    truth_table_sweeper #(.N_IN(3), .DWELL(4)) u_dut_a (
        .clk           (clk),
        .reset         (rst),
        .start         (start_a),
        .mode          (mode_a),
        .dut_out       (dut_a),
        .vec_out       (vec_a),
        .busy          (busy_a),
        .done          (done_a),
        .pass          (pass_a),
        .err_cnt       (err_a),
        .first_err_vec (first_a)
    );

    truth_table_sweeper #(.N_IN(4), .DWELL(1)) u_dut_b (
        .clk           (clk),
        .reset         (rst),
        .start         (start_b),
        .mode          (mode_b),
        .dut_out       (dut_b),
        .vec_out       (vec_b),
        .busy          (busy_b),
        .done          (done_b),
        .pass          (pass_b),
        .err_cnt       (err_b),
        .first_err_vec (first_b)
    );

    // Gate under test for instance A: 0 = AND, 1 = stuck-at-0, else OR
    always_comb begin
        dut_a = 1'b0;
        case (kind_a)
            2'd0:    dut_a = &vec_a;
            2'd1:    dut_a = 1'b0;
            default: dut_a = |vec_a;
        endcase
    end
    assign dut_b = |vec_b;

    function automatic int fe(input int v);
        return FE_ON ? v : 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor A: vector sequence during busy, result fields on done
    always @(negedge clk) begin
        if (rst) begin
            run_a = 0;
        end else begin
            if (busy_a) begin
                chk("vec_seq_a", {29'd0, vec_a}, run_a / 4);
                run_a++;
            end
            if (done_a) begin
                chk("busy_at_done_a", {31'd0, busy_a}, 0);
                if (q_a.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done_a actual=done required=no_done");
                end else begin
                    e_a = q_a.pop_front();
                    chk("err_cnt_a",    {28'd0, err_a},   e_a.err);
                    chk("pass_a",       {31'd0, pass_a},  e_a.pass);
                    chk("first_err_a",  {29'd0, first_a}, e_a.first);
                    chk("busy_cycles_a", run_a,           e_a.busy);
                end
                run_a = 0;
            end
        end
    end

    // Monitor B: same checks for the single-cycle-dwell instance
    always @(negedge clk) begin
        if (rst) begin
            run_b = 0;
        end else begin
            if (busy_b) begin
                chk("vec_seq_b", {28'd0, vec_b}, run_b);
                run_b++;
            end
            if (done_b) begin
                if (q_b.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done_b actual=done required=no_done");
                end else begin
                    e_b = q_b.pop_front();
                    chk("err_cnt_b",    {27'd0, err_b},   e_b.err);
                    chk("pass_b",       {31'd0, pass_b},  e_b.pass);
                    chk("first_err_b",  {28'd0, first_b}, e_b.first);
                    chk("busy_cycles_b", run_b,           e_b.busy);
                end
                run_b = 0;
            end
        end
    end

    task automatic go_a(input logic [1:0] m, input logic [1:0] k,
                        input int e_err, input int e_pass, input int e_first, input int e_busy);
        exp_t e;
        e.err = e_err; e.pass = e_pass; e.first = e_first; e.busy = e_busy;
        q_a.push_back(e);
        @(negedge clk);
        kind_a  = k;
        mode_a  = m;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic go_b(input logic [1:0] m,
                        input int e_err, input int e_pass, input int e_first, input int e_busy);
        exp_t e;
        e.err = e_err; e.pass = e_pass; e.first = e_first; e.busy = e_busy;
        q_b.push_back(e);
        @(negedge clk);
        mode_b  = m;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
    endtask

    task automatic wait_done_a();
        int n = 0;
        while (!done_a && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout_a", {31'd0, done_a}, 1);
        @(negedge clk);
    endtask

    task automatic wait_done_b();
        int n = 0;
        while (!done_b && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout_b", {31'd0, done_b}, 1);
        @(negedge clk);
    endtask

    task automatic wait_vec_a(input logic [2:0] target);
        int n = 0;
        while (vec_a != target && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("vec_reach_a", {29'd0, vec_a}, {29'd0, target});
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_vec_out"}, {29'd0, vec_a},   0);
        chk({tag, "_busy"},    {31'd0, busy_a},  0);
        chk({tag, "_done"},    {31'd0, done_a},  0);
        chk({tag, "_pass"},    {31'd0, pass_a},  0);
        chk({tag, "_err_cnt"}, {28'd0, err_a},   0);
        chk({tag, "_first"},   {29'd0, first_a}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        mode_a  = MODE_AND;
        mode_b  = MODE_OR;
        kind_a  = 2'd0;
        repeat (3) @(negedge clk);
        chk_reset_a("reset");
        rst = 1'b0;

        // Correct AND gate judged as AND
        go_a(MODE_AND, 2'd0, 0, 1, 0, 32);
        wait_done_a();
        repeat (3) @(negedge clk);
        chk("pass_held_a", {31'd0, pass_a}, 1);

        // Stuck-at-0 output: only vector 7 disagrees with AND
        go_a(MODE_AND, 2'd1, 1, 0, fe(7), 32);
        wait_done_a();

        // AND gate judged as XOR: vectors 1, 2, 4 disagree
        go_a(MODE_XOR, 2'd0, 3, 0, fe(1), 32);
        wait_done_a();

        // AND gate judged as NAND: every vector disagrees, count hits 2^N_IN
        go_a(MODE_NAND, 2'd0, 8, 0, fe(0), 32);
        wait_done_a();

        // Reset in the middle of a sweep: no done, all outputs back to reset
        @(negedge clk);
        kind_a  = 2'd0;
        mode_a  = MODE_AND;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_vec_a(3'd5);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_a("midreset");
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("midreset_idle_busy", {31'd0, busy_a}, 0);
        go_a(MODE_AND, 2'd0, 0, 1, 0, 32);
        wait_done_a();

        // Start pulse and mode change while busy are both ignored
        go_a(MODE_AND, 2'd0, 0, 1, 0, 32);
        wait_vec_a(3'd2);
        mode_a  = MODE_OR;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done_a();

        // Single-cycle dwell, 4-input OR gate
        go_b(MODE_OR, 0, 1, 0, 16);
        wait_done_b();
        go_b(MODE_AND, 14, 0, fe(1), 16);
        wait_done_b();

        repeat (4) @(negedge clk);
        chk("queue_a_drained", q_a.size(), 0);
        chk("queue_b_drained", q_b.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
